ifmap_addr_gen: RTL and testbench

- Read-address generator for the input-feature-map buffer of the depthwise convolution engine.
- Walks an IW x IH map in output tiles of POX x POY. For each tile it issues one AXI-style read burst per input row of the tile, then hands the block to compute.
- On each result_valid it advances to the next tile, until the whole map is covered.
- Sits between the input buffer/compute controller and the AXI read-address channel.

---
 rtl/ifmap_addr_gen.sv | 146 ++++++++++++++
 tb/tb_ifmap_addr_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_addr_gen.sv
// Read-address generator for the depthwise-conv input-feature-map buffer.
// The generator walks the input map in output tiles. For each tile it issues
// one INCR burst per input row, waits for compute to finish, then moves to the
// next tile origin.
module ifmap_addr_gen #(
    parameter int AW     = 32,
    parameter int KSIZE  = 3,
    parameter int POX    = 15,
    parameter int POY    = 3,
    parameter int STRIDE = 2,
    parameter int IW     = 224,
    parameter int IH     = 224,
    parameter int BURST  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_addr_en,
    input  logic [AW-1:0] init_addr,
    input  logic          rlast,
    input  logic          result_valid,
    output logic          arvalid,
    output logic [AW-1:0] araddr,
    output logic [3:0]    arburst,
    output logic          data_load,
    output logic          blkend,
    output logic          dw_comp,
    output logic          mapend
);

    // Input tile footprint, tile-to-tile steps and last legal origin bounds.
    localparam int TW    = (POX - 1) * STRIDE + KSIZE;
    localparam int TH    = (POY - 1) * STRIDE + KSIZE;
    localparam int XSTEP = POX * STRIDE;
    localparam int YSTEP = POY * STRIDE;
    localparam int XLIM  = IW - KSIZE + 1;
    localparam int YLIM  = IH - KSIZE + 1;
    localparam int RW    = $clog2(TH + 1);

    // A burst shorter than a tile row would silently truncate every row, so a
    // misconfigured instance refuses to start instead.
    localparam bit CFG_OK = (BURST >= TW);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_COMP} state_t;

    state_t        state;
    logic [AW-1:0] base;
    logic [AW-1:0] ox;
    logic [AW-1:0] oy;
    logic [RW-1:0] row;
    logic [AW-1:0] nx;
    logic [AW-1:0] ny;

    // Start address of one tile row; wraps modulo 2^AW by construction.
    function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] b,
                                               input logic [AW-1:0] x,
                                               input logic [AW-1:0] y,
                                               input logic [RW-1:0] r);
        row_addr = b + (y + AW'(r)) * AW'(IW) + x;
    endfunction

    // Candidate next tile origins, evaluated while compute is pending.
    always_comb begin
        nx = ox + AW'(XSTEP);
        ny = oy + AW'(YSTEP);
    end

    // Only INCR bursts are ever requested.
    assign arburst = 4'd1;

    // Tile walker FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            arvalid   <= 1'b0;
            araddr    <= '0;
            data_load <= 1'b0;
            blkend    <= 1'b0;
            dw_comp   <= 1'b0;
            mapend    <= 1'b0;
            ox        <= '0;
            oy        <= '0;
            row       <= '0;
        end else begin
            arvalid <= 1'b0;
            blkend  <= 1'b0;
            mapend  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_addr_en && CFG_OK) begin
                        base    <= init_addr;
                        ox      <= '0;
                        oy      <= '0;
                        row     <= '0;
                        araddr  <= init_addr;
                        arvalid <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    data_load <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (rlast) begin
                        data_load <= 1'b0;
                        if (row < RW'(TH - 1)) begin
                            row     <= row + RW'(1);
                            araddr  <= row_addr(base, ox, oy, row + RW'(1));
                            arvalid <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            row     <= '0;
                            blkend  <= 1'b1;
                            dw_comp <= 1'b1;
                            state   <= S_COMP;
                        end
                    end
                end
                S_COMP: begin
                    if (result_valid) begin
                        dw_comp <= 1'b0;
                        if (nx < AW'(XLIM)) begin
                            ox      <= nx;
                            araddr  <= row_addr(base, nx, oy, '0);
                            arvalid <= 1'b1;
                            state   <= S_REQ;
                        end else if (ny < AW'(YLIM)) begin
                            ox      <= '0;
                            oy      <= ny;
                            araddr  <= row_addr(base, '0, ny, '0);
                            arvalid <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            ox     <= '0;
                            oy     <= '0;
                            mapend <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_addr_gen.sv
// Testbench for ifmap_addr_gen: random-latency bus responder, random compute
// delays, and a scoreboard fed from a tile-walk reference of the whole map.
module tb_ifmap_addr_gen;

    localparam int IW    = 224;
    localparam int IH    = 224;
    localparam int K     = 3;
    localparam int TH    = 7;
    localparam int XSTEP = 30;
    localparam int YSTEP = 6;
    localparam int XLIM  = IW - K + 1;
    localparam int YLIM  = IH - K + 1;
    localparam int TOTAL = ((XLIM - 1) / XSTEP + 1) * ((YLIM - 1) / YSTEP + 1);
    localparam int BURST = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_addr_en;
    logic [31:0] init_addr;
    logic        rlast = 1'b0;
    logic        result_valid;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arburst;
    logic        data_load;
    logic        blkend;
    logic        dw_comp;
    logic        mapend;

    int          checks = 0;
    int          errors = 0;
    int          mapend_cnt = 0;
    bit          full_beats = 1'b1;
    bit          abort_run = 1'b0;
    logic [31:0] exp_q[$];

    ifmap_addr_gen dut (
        .clk(clk), .rst(rst), .init_addr_en(init_addr_en), .init_addr(init_addr),
        .rlast(rlast), .result_valid(result_valid), .arvalid(arvalid),
        .araddr(araddr), .arburst(arburst), .data_load(data_load),
        .blkend(blkend), .dw_comp(dw_comp), .mapend(mapend)
    );

    always #5 clk = ~clk;

    // Reference: every burst address of the map, in tile-walk order.
    task automatic push_map(input logic [31:0] b);
        for (int ty = 0; ty < YLIM; ty += YSTEP)
            for (int tx = 0; tx < XLIM; tx += XSTEP)
                for (int r = 0; r < TH; r++)
                    exp_q.push_back(b + 32'((ty + r) * IW + tx));
    endtask

    // Bus responder: after each request, a short latency then the beats, rlast on the last.
    initial begin
        forever begin
            if (arvalid && !rst) begin
                int  lat;
                int  nb;
                bit  ab;
                lat = $urandom_range(1, 3);
                nb  = full_beats ? BURST : $urandom_range(1, BURST);
                ab  = 1'b0;
                for (int i = 0; i < lat + nb - 1 && !ab; i++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                if (!ab) begin
                    rlast = 1'b1;
                    @(negedge clk);
                    rlast = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: protocol expectations per cycle plus address scoreboard.
    bit m_active = 0, m_just = 0, m_comp = 0;
    int m_rows = 0, m_tiles = 0;
    always @(posedge clk) begin
        logic [4:0]  ev;
        logic [4:0]  gv;
        logic [31:0] ea;
        #1;
        ev = '0;
        gv = {arvalid, data_load, blkend, dw_comp, mapend};
        if (rst) begin
            m_active = 0; m_just = 0; m_comp = 0; m_rows = 0; m_tiles = 0;
            exp_q.delete();
            checks++;
            if (gv != 5'b0 || araddr != 32'd0 || arburst != 4'd1) begin
                errors++;
                $display("FAIL reset_state t=%0t got ctl=%b addr=%0d burst=%0d want ctl=00000 addr=0 burst=1",
                         $time, gv, araddr, arburst);
            end
        end else begin
            if (!m_active) begin
                if (init_addr_en) begin
                    m_active = 1; m_rows = 0; m_tiles = 0; ev[4] = 1'b1;
                end
            end else if (m_just) begin
                ev[3] = 1'b1;
            end else if (m_comp) begin
                if (result_valid) begin
                    m_comp = 0;
                    m_tiles++;
                    if (m_tiles == TOTAL) begin
                        ev[0] = 1'b1;
                        m_active = 0;
                    end else begin
                        ev[4] = 1'b1;
                    end
                end else begin
                    ev[1] = 1'b1;
                end
            end else begin
                if (rlast) begin
                    m_rows++;
                    if (m_rows == TH) begin
                        m_rows = 0; m_comp = 1; ev[2] = 1'b1; ev[1] = 1'b1;
                    end else begin
                        ev[4] = 1'b1;
                    end
                end else begin
                    ev[3] = 1'b1;
                end
            end
            m_just = ev[4];
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL ctl {arvalid,data_load,blkend,dw_comp,mapend} t=%0t got=%b want=%b",
                         $time, gv, ev);
            end
            if (mapend) mapend_cnt++;
            if (ev[4] && arvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL araddr t=%0t got=%0d want=<none queued>", $time, araddr);
                end else begin
                    ea = exp_q.pop_front();
                    if (araddr !== ea) begin
                        errors++;
                        $display("FAIL araddr t=%0t got=%0d want=%0d", $time, araddr, ea);
                    end
                end
            end
        end
    end

    task automatic issue_init(input logic [31:0] b);
        @(negedge clk);
        push_map(b);
        init_addr    = b;
        init_addr_en = 1'b1;
        @(negedge clk);
        init_addr_en = 1'b0;
    endtask

    // Load one tile (with ignored stray inputs), then return result cdelay cycles after blkend.
    task automatic do_tile(input int cdelay);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (dw_comp) break;
            result_valid = ($urandom_range(0, 15) == 0);
            init_addr_en = ($urandom_range(0, 15) == 0);
            init_addr    = $urandom;
        end
        result_valid = 1'b0;
        init_addr_en = 1'b0;
        if (!dw_comp) begin
            checks++;
            errors++;
            $display("FAIL tile_timeout t=%0t got dw_comp=0 want dw_comp=1", $time);
            abort_run = 1'b1;
            return;
        end
        for (int i = 1; i < cdelay; i++) begin
            @(negedge clk);
            init_addr_en = ($urandom_range(0, 3) == 0);
        end
        init_addr_en = 1'b0;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int n;
        rst          = 1'b1;
        init_addr_en = 1'b0;
        init_addr    = '0;
        result_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Whole map from base 0: first tiles with full 32-beat bursts.
        full_beats = 1'b1;
        issue_init(32'd0);
        for (int t = 0; t < TOTAL && !abort_run; t++) begin
            if (t == 2) full_beats = 1'b0;
            do_tile(t == 0 ? 13 : $urandom_range(1, 16));
        end
        repeat (20) @(negedge clk);
        checks++;
        if (mapend_cnt != 1) begin
            errors++;
            $display("FAIL mapend_count got=%0d want=1", mapend_cnt);
        end

        // Reset in the middle of the third row's burst, then restart at 1000.
        full_beats = 1'b1;
        issue_init(32'd0);
        cnt = int'(arvalid);
        n   = 0;
        while (cnt < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (arvalid) cnt++;
        end
        if (cnt < 3) begin
            checks++;
            errors++;
            $display("FAIL third_row_timeout got=%0d requests want=3", cnt);
        end
        repeat (4) @(negedge clk);
        pulse_rst();
        issue_init(32'd1000);
        abort_run = 1'b0;
        for (int t = 0; t < 3 && !abort_run; t++) do_tile($urandom_range(1, 16));

        // Base near the top of the address space: addresses wrap modulo 2^32.
        pulse_rst();
        full_beats = 1'b0;
        issue_init(32'hFFFF_FF80);
        abort_run = 1'b0;
        for (int t = 0; t < 9 && !abort_run; t++) do_tile($urandom_range(1, 16));
        pulse_rst();
        repeat (5) @(negedge clk);

        checks++;
        if (mapend_cnt != 1) begin
            errors++;
            $display("FAIL mapend_total got=%0d want=1", mapend_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
